// File: rtl/divider.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Ports:
//   clk, resetn         - clock (rising edge), asynchronous active-low reset
//   div_valid/div_ready - request handshake; div_ready is decoded from state
//   sign                - 1 = signed (DIV), 0 = unsigned (DIVU); latched on accept
//   x, y                - dividend, divisor; latched on accept
//   cancel              - abort an in-flight operation, results untouched
//   busy                - operation in flight
//   done                - one-cycle pulse, quot/rem/div_zero valid
//   quot, rem           - quotient (LO) and remainder (HI)
//   div_zero            - last completed operation had y == 0
module divider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        sign,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {IDLE, PREP, ITER, POST} state_t;

  state_t          state, state_next;
  logic            sign_q;
  logic [W-1:0]    x_q, y_q;
  logic [W-1:0]    ay;
  logic [W-1:0]    r_acc, q_acc;
  logic            qneg, rneg, zero;
  logic [CW-1:0]   cnt;

  logic            accept_c;
  logic [W-1:0]    ax_c, ay_c;
  logic [W:0]      r_sh_c, diff_c;
  logic [W-1:0]    q_fin_c, r_fin_c;

  assign div_ready = (state == IDLE);
  assign accept_c  = div_valid && (state == IDLE);

  // Operand magnitudes; |0x80000000| stays 0x80000000 as an unsigned value.
  assign ax_c = (sign_q && x_q[W-1]) ? W'(-x_q) : x_q;
  assign ay_c = (sign_q && y_q[W-1]) ? W'(-y_q) : y_q;

  // One restoring step: shift {R,Q} left, trial-subtract |y| in W+1 bits.
  assign r_sh_c = {r_acc, q_acc[W-1]};
  assign diff_c = r_sh_c - {1'b0, ay};

  assign q_fin_c = qneg ? W'(-q_acc) : q_acc;
  assign r_fin_c = rneg ? W'(-r_acc) : r_acc;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_c) state_next = PREP;
      PREP: state_next = cancel ? IDLE : ITER;
      ITER: begin
        if (cancel)                      state_next = IDLE;
        else if (cnt == CW'(W - 1))      state_next = POST;
      end
      POST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sign_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ay       <= '0;
      r_acc    <= '0;
      q_acc    <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      zero     <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (accept_c) begin
            sign_q <= sign;
            x_q    <= x;
            y_q    <= y;
          end
        end
        PREP: begin
          ay    <= ay_c;
          q_acc <= ax_c;
          r_acc <= '0;
          qneg  <= sign_q & (x_q[W-1] ^ y_q[W-1]);
          rneg  <= sign_q & x_q[W-1];
          zero  <= (y_q == '0);
          cnt   <= '0;
        end
        ITER: begin
          if (!diff_c[W]) begin
            r_acc <= diff_c[W-1:0];
            q_acc <= {q_acc[W-2:0], 1'b1};
          end else begin
            r_acc <= r_sh_c[W-1:0];
            q_acc <= {q_acc[W-2:0], 1'b0};
          end
          cnt <= CW'(cnt + 1'b1);
        end
        POST: begin
          // A cancel here drops the result and leaves the outputs as they were.
          if (!cancel) begin
            done     <= 1'b1;
            div_zero <= zero;
            quot     <= zero ? '1  : q_fin_c;
            rem      <= zero ? x_q : r_fin_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: expected results are queued on issue and
// compared whenever done pulses; latency, busy, cancel and reset checked inline.
module tb_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_ready;
  logic        sign;
  logic [31:0] x, y;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] quot, rem;
  logic        div_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  exp_t last_e;
  int   total = 0;
  int   bad   = 0;
  int   lat, bcnt;

  divider dut (
    .clk(clk), .resetn(resetn), .div_valid(div_valid), .div_ready(div_ready),
    .sign(sign), .x(x), .y(y), .cancel(cancel), .busy(busy), .done(done),
    .quot(quot), .rem(rem), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain division on sign-extended 64-bit operands.
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      e.q = 32'(sa / sb); e.r = 32'(sa % sb); e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input bit c);
    check("ready_before_issue", div_ready, 1);
    sign = s; x = a; y = b; div_valid = 1'b1; cancel = c;
    if (push) begin
      sbq.push_back(model(s, a, b));
      last_e = model(s, a, b);
    end
    @(posedge clk); #1;
    div_valid = 1'b0; cancel = 1'b0;
    check("busy_after_accept", busy, 1);
    check("ready_after_accept", div_ready, 0);
  endtask

  // Counts edges from accept to done and cycles with busy high.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = int'(busy);
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      bc += int'(busy);
    end
    if (!done) check("done_timeout", 0, 1);
    else begin
      check("busy_in_done", busy, 0);
      check("ready_in_done", div_ready, 1);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (sbq.size() == 0) check("spurious_done", 1, 0);
      else begin
        mon_e = sbq.pop_front();
        check("quot", quot, mon_e.q);
        check("rem", rem, mon_e.r);
        check("div_zero", div_zero, mon_e.dz);
      end
    end
  end

  initial begin
    resetn = 1'b0; div_valid = 1'b0; sign = 1'b0; x = '0; y = '0; cancel = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", div_ready, 1);
    check("rst_done", done, 0);
    check("rst_quot", quot, 0);
    check("rst_rem", rem, 0);
    check("rst_dz", div_zero, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // Unsigned 100/7: latency and busy width
    issue(0, 32'd100, 32'd7, 1, 0);
    wait_done(lat, bcnt);
    check("lat_100_7", lat, 34);
    check("busy_cycles", bcnt, 34);
    check("q_100_7", quot, 14);
    check("r_100_7", rem, 2);

    // Signed corner cases, each issued back-to-back in the previous done cycle
    issue(1, 32'hFFFF_FFF9, 32'd2, 1, 0);
    wait_done(lat, bcnt);
    check("lat_b2b", lat, 34);
    check("q_m7_2", quot, 32'hFFFF_FFFD);
    check("r_m7_2", rem, 32'hFFFF_FFFF);

    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    wait_done(lat, bcnt);
    check("q_min_m1", quot, 32'h8000_0000);
    check("r_min_m1", rem, 0);

    issue(0, 32'hFFFF_FFFF, 32'h10, 1, 0);
    wait_done(lat, bcnt);
    check("q_ffff_10", quot, 32'h0FFF_FFFF);
    check("r_ffff_10", rem, 32'hF);

    // Divide by zero, both signednesses
    for (int s = 0; s < 2; s++) begin
      issue(s[0], 32'h1234_5678, 32'd0, 1, 0);
      wait_done(lat, bcnt);
      check("lat_dz", lat, 34);
      check("q_dz", quot, 32'hFFFF_FFFF);
      check("r_dz", rem, 32'h1234_5678);
      check("dz_flag", div_zero, 1);
    end

    // cancel together with div_valid in IDLE: request still accepted
    issue(1, 32'hFFFF_FF38, 32'd9, 1, 1);
    wait_done(lat, bcnt);
    check("lat_cancel_idle", lat, 34);

    // Cancel ten cycles after accept
    issue(0, 32'd1000, 32'd3, 0, 0);
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_ready", div_ready, 1);
    check("cancel_done", done, 0);
    check("cancel_quot_kept", quot, last_e.q);
    check("cancel_rem_kept", rem, last_e.r);
    check("cancel_dz_kept", div_zero, last_e.dz);
    issue(0, 32'd50, 32'd5, 1, 0);
    wait_done(lat, bcnt);
    check("lat_50_5", lat, 34);
    check("q_50_5", quot, 10);
    check("r_50_5", rem, 0);

    // Random operations, chained back-to-back
    for (int i = 0; i < 8; i++) begin
      issue(i[0], $urandom, (i % 3 == 0) ? 32'($urandom_range(1, 255)) : 32'($urandom), 1, 0);
      wait_done(lat, bcnt);
      check("lat_rand", lat, 34);
    end

    // Asynchronous reset mid-ITER
    issue(1, 32'hDEAD, 32'd7, 0, 0);
    repeat (15) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", div_ready, 1);
    check("arst_done", done, 0);
    check("arst_quot", quot, 0);
    check("arst_rem", rem, 0);
    check("arst_dz", div_zero, 0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    issue(0, 32'd9, 32'd3, 1, 0);
    wait_done(lat, bcnt);
    check("lat_9_3", lat, 34);
    check("q_9_3", quot, 3);
    check("r_9_3", rem, 0);

    repeat (40) @(posedge clk);
    #1;
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit integer divider for the MIPS-lite execute stage, the counterpart of the combinational Booth/Wallace multiplier. Serves DIV and DIVU: accepts dividend and divisor under a valid/ready handshake, runs a radix-2 restoring loop on operand magnitudes, applies sign correction, and returns quotient (LO) and remainder (HI) with a one-cycle done pulse. Fixed latency; the pipeline stalls on `busy`.

## Interface
- None. Datapath is fixed at 32 bits; the iteration count is fixed at 32.

- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `div_valid` in 1: request strobe.
- `div_ready` out 1: high when a request can be accepted (`!busy`).
- `sign` in 1: 1 = signed (DIV), 0 = unsigned (DIVU); sampled on accept.
- `x` in 32: dividend; sampled on accept.
- `y` in 32: divisor; sampled on accept.
- `cancel` in 1: abort the in-flight operation (exception/flush).
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse; results valid.
- `quot` out 32: quotient (to LO).
- `rem` out 32: remainder (to HI).
- `div_zero` out 1: the last completed operation had `y == 0`.

## Operation
- Accept: rising edge with `div_valid && div_ready`. Latches `sign`, `x`, `y`.
- FSM states: IDLE, PREP, ITER, POST.
  - IDLE -> PREP on accept.
  - PREP (1 cycle): form magnitudes. When `sign`=1, use two's-complement absolute values; otherwise use raw values. Record `qneg = sign & (x[31]^y[31])`, `rneg = sign & x[31]`, and `zero = (y == 0)`. Clear the 32-bit partial remainder; load the quotient shift register with |x|. -> ITER, counter = 0.
  - ITER (32 cycles): shift {R,Q} left 1. Trial subtract R - |y| in 33 bits. If the result is non-negative, R takes the difference and Q[0]=1; otherwise Q[0]=0. Counter 0..31; -> POST after count 31.
  - POST (1 cycle): `quot` = qneg ? -Q : Q; `rem` = rneg ? -R : R. If zero: `quot`=32'hFFFFFFFF, `rem`=original `x`, `div_zero`=1, else `div_zero`=0. Assert `done`. -> IDLE.
- Magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000, so 0x80000000 / -1 yields quot=0x80000000, rem=0 (MIPS wrap, no trap).
- Remainder sign always follows the dividend; |rem| < |y|.
- Divide-by-zero takes the full latency; no early exit.
- `cancel` in PREP/ITER/POST: the next edge goes to IDLE. `done` is not asserted. `quot`/`rem`/`div_zero` keep their previous values. `cancel` in IDLE has no effect. `cancel` and `div_valid` in the same IDLE cycle: the request is accepted (cancel ignored).
- `quot`, `rem`, `div_zero` change only in POST and hold until the next POST.

## Timing
- Reset values: state IDLE, `busy`=0, `div_ready`=1, `done`=0, `quot`=0, `rem`=0, `div_zero`=0, counter 0.
- Reset mid-operation: asynchronous return to the reset values; no `done`.
- Latency: accept on edge E0; PREP E0->E1; ITER E1->E33; POST E33->E34. `done`=1 and results visible in the cycle after E34 (34 edges after accept).
- `busy`=1 from the cycle after E0 through the cycle before `done`. In the `done` cycle `busy`=0 and `div_ready`=1, so a back-to-back request is accepted at the edge ending the `done` cycle.
- `done` is exactly one cycle wide, registered, and never asserted without a prior accept.
- `div_ready` is combinational from state only.

## Test plan
- Unsigned 100/7 (`sign`=0): `done` 34 edges after accept; quot=14, rem=2, `div_zero`=0; `busy` high 34 cycles.
- Signed -7/2 (x=0xFFFFFFF9, y=2): quot=0xFFFFFFFD, rem=0xFFFFFFFF. Signed 0x80000000/0xFFFFFFFF: quot=0x80000000, rem=0. Unsigned 0xFFFFFFFF/0x10: quot=0x0FFFFFFF, rem=0xF.
- Divide by zero, x=0x12345678, y=0, both signs: quot=0xFFFFFFFF, rem=0x12345678, `div_zero`=1, same 34-cycle latency.
- Cancel 10 cycles after accept: IDLE next edge, no `done`, outputs unchanged. A new request (50/5) is then accepted immediately and yields quot=10, rem=0.
- Back-to-back: second request held valid during the first `done` cycle is accepted there; its `done` follows 34 edges later with correct results.
- Deassert `resetn` mid-ITER: all outputs reach their reset values immediately, without waiting for a clock edge; after release, 9/3 completes with quot=3, rem=0.
